bicubic_fetch_ctrl: RTL and testbench

Sequencing controller for the bicubic scaler datapath. It latches a scaling job (source window origin/size, target size), derives the fixed-point source step with a serial divider, and walks target pixels in raster order. For each target pixel it fetches the 4x4 source neighbourhood from ImgROM, hands the window and fractional offsets to the interpolation engine, and writes the returned pixel into ResultSRAM. It pulses DONE when the job completes.

---
 rtl/bicubic_fetch_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_bicubic_fetch_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bicubic_fetch_ctrl.sv
// Bicubic scaler sequencer: latches a job, derives the source steps with a
// serial restoring divider, then walks target pixels in raster order. Each
// pixel gets a 4x4 ROM neighbourhood (reused when the base is unchanged), is
// offered to the interpolation engine, and its result is written to SRAM.
module bicubic_fetch_ctrl #(
  parameter int IMG_W = 100,
  parameter int IMG_H = 100
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [6:0]   V0,
  input  logic [6:0]   H0,
  input  logic [4:0]   SH,
  input  logic [4:0]   SW,
  input  logic [5:0]   TH,
  input  logic [5:0]   TW,
  output logic         img_cen,
  output logic [13:0]  img_addr,
  input  logic [7:0]   img_data,
  output logic         win_valid,
  input  logic         win_ready,
  output logic [127:0] win_data,
  output logic [7:0]   win_dx,
  output logic [7:0]   win_dy,
  input  logic         res_valid,
  input  logic [7:0]   res_data,
  output logic         res_cen,
  output logic         res_wen,
  output logic [11:0]  res_addr,
  output logic [7:0]   res_d,
  output logic         busy,
  output logic         DONE
);

  typedef enum logic [3:0] {
    S_IDLE, S_DIV, S_POS, S_FETCH, S_OFFER, S_WAIT_RES, S_WRITE, S_ADV, S_FIN
  } state_t;

  localparam logic signed [9:0] ROW_MAX = 10'(IMG_H - 1);
  localparam logic signed [9:0] COL_MAX = 10'(IMG_W - 1);

  state_t      state;
  logic [6:0]  v0_q, h0_q;
  logic [4:0]  sh_q;
  logic [5:0]  th_q, tw_q;
  logic [12:0] dvd;
  logic [5:0]  rem;
  logic [11:0] quot;
  logic [4:0]  div_cnt;
  logic [12:0] step_x, step_y;
  // Positions are 16 bits so an origin of 127 plus a 31-pixel window still fits.
  logic [15:0] pos_x, pos_y;
  logic [5:0]  tx, ty;
  logic [7:0]  base_x, base_y;
  logic        held;
  logic [4:0]  fk;

  logic [7:0]  bx, by;
  logic [5:0]  dsor;
  logic [6:0]  rem_sh;
  logic        q_bit;
  logic [5:0]  rem_nx;
  logic [12:0] quot_nx;
  logic [3:0]  slot;

  // Clamped neighbourhood address for tap k around base (bx, by).
  function automatic logic [13:0] fetch_addr(input logic [7:0] fbx, input logic [7:0] fby,
                                             input logic [3:0] k);
    logic signed [9:0] r;
    logic signed [9:0] c;
    r = $signed({2'b00, fby}) - 10'sd1 + $signed({8'd0, k[3:2]});
    c = $signed({2'b00, fbx}) - 10'sd1 + $signed({8'd0, k[1:0]});
    if (r < 10'sd0) r = 10'sd0;
    else if (r > ROW_MAX) r = ROW_MAX;
    if (c < 10'sd0) c = 10'sd0;
    else if (c > COL_MAX) c = COL_MAX;
    return 14'(r * IMG_W + c);
  endfunction

  assign bx   = pos_x[15:8];
  assign by   = pos_y[15:8];
  assign slot = 4'(fk - 5'd1);

  // One restoring-division step; first 13 steps divide by TW, next 13 by TH.
  always_comb begin
    dsor    = (div_cnt < 5'd13) ? tw_q : th_q;
    rem_sh  = {rem, dvd[12]};
    q_bit   = (rem_sh >= {1'b0, dsor});
    rem_nx  = q_bit ? 6'(rem_sh - {1'b0, dsor}) : rem_sh[5:0];
    quot_nx = {quot, q_bit};
  end

  // Job sequencer with registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      held      <= 1'b0;
      busy      <= 1'b0;
      DONE      <= 1'b0;
      img_cen   <= 1'b1;
      img_addr  <= '0;
      win_valid <= 1'b0;
      win_data  <= '0;
      win_dx    <= '0;
      win_dy    <= '0;
      res_cen   <= 1'b1;
      res_wen   <= 1'b1;
      res_addr  <= '0;
      res_d     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            v0_q    <= V0;
            h0_q    <= H0;
            sh_q    <= SH;
            th_q    <= TH;
            tw_q    <= TW;
            dvd     <= {SW, 8'h00};
            rem     <= '0;
            quot    <= '0;
            div_cnt <= '0;
            busy    <= 1'b1;
            state   <= S_DIV;
          end
        end
        S_DIV: begin
          div_cnt <= div_cnt + 5'd1;
          if (div_cnt == 5'd12) begin
            step_x <= quot_nx;
            dvd    <= {sh_q, 8'h00};
            rem    <= '0;
            quot   <= '0;
          end else begin
            dvd  <= {dvd[11:0], 1'b0};
            rem  <= rem_nx;
            quot <= quot_nx[11:0];
          end
          if (div_cnt == 5'd25) begin
            step_y <= quot_nx;
            pos_x  <= {1'b0, h0_q, 8'h00};
            pos_y  <= {1'b0, v0_q, 8'h00};
            tx     <= '0;
            ty     <= '0;
            state  <= S_POS;
          end
        end
        S_POS: begin
          win_dx <= pos_x[7:0];
          win_dy <= pos_y[7:0];
          base_x <= bx;
          base_y <= by;
          if (held && bx == base_x && by == base_y) begin
            win_valid <= 1'b1;
            state     <= S_OFFER;
          end else begin
            held     <= 1'b0;
            img_cen  <= 1'b0;
            img_addr <= fetch_addr(bx, by, 4'd0);
            fk       <= '0;
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (fk < 5'd15) img_addr <= fetch_addr(base_x, base_y, 4'(fk + 5'd1));
          if (fk == 5'd15) img_cen <= 1'b1;
          if (fk != 5'd0) win_data[{slot, 3'b000} +: 8] <= img_data;
          if (fk == 5'd16) begin
            held      <= 1'b1;
            win_valid <= 1'b1;
            state     <= S_OFFER;
          end else begin
            fk <= fk + 5'd1;
          end
        end
        S_OFFER: begin
          if (win_ready) begin
            win_valid <= 1'b0;
            state     <= S_WAIT_RES;
          end
        end
        S_WAIT_RES: begin
          if (res_valid) begin
            res_d    <= res_data;
            res_addr <= {6'd0, ty} * {6'd0, tw_q} + {6'd0, tx};
            res_cen  <= 1'b0;
            res_wen  <= 1'b0;
            state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          res_cen <= 1'b1;
          res_wen <= 1'b1;
          state   <= S_ADV;
        end
        S_ADV: begin
          if (tx < tw_q - 6'd1) begin
            tx    <= tx + 6'd1;
            pos_x <= pos_x + {3'b000, step_x};
            state <= S_POS;
          end else if (ty < th_q - 6'd1) begin
            tx    <= '0;
            ty    <= ty + 6'd1;
            pos_x <= {1'b0, h0_q, 8'h00};
            pos_y <= pos_y + {3'b000, step_y};
            state <= S_POS;
          end else begin
            DONE  <= 1'b1;
            busy  <= 1'b0;
            state <= S_FIN;
          end
        end
        S_FIN: begin
          DONE  <= 1'b0;
          held  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bicubic_fetch_ctrl.sv
// Scoreboard bench for bicubic_fetch_ctrl: a job-level model queues the ROM
// reads, windows, SRAM writes and DONE pulses; a monitor checks them as the
// DUT presents them.
module tb_bicubic_fetch_ctrl;

  logic         CLK = 1'b0;
  logic         RST, START;
  logic [6:0]   V0, H0;
  logic [4:0]   SH, SW;
  logic [5:0]   TH, TW;
  logic         img_cen;
  logic [13:0]  img_addr;
  logic [7:0]   img_data;
  logic         win_valid, win_ready;
  logic [127:0] win_data;
  logic [7:0]   win_dx, win_dy;
  logic         res_valid;
  logic [7:0]   res_data;
  logic         res_cen, res_wen;
  logic [11:0]  res_addr;
  logic [7:0]   res_d;
  logic         busy, DONE;

  always #5 CLK = ~CLK;

  bicubic_fetch_ctrl #(.IMG_W(100), .IMG_H(100)) dut (
    .CLK(CLK), .RST(RST), .START(START), .V0(V0), .H0(H0), .SH(SH), .SW(SW),
    .TH(TH), .TW(TW), .img_cen(img_cen), .img_addr(img_addr), .img_data(img_data),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .win_dx(win_dx), .win_dy(win_dy), .res_valid(res_valid), .res_data(res_data),
    .res_cen(res_cen), .res_wen(res_wen), .res_addr(res_addr), .res_d(res_d),
    .busy(busy), .DONE(DONE)
  );

  typedef struct packed { logic [127:0] d; logic [7:0] dx; logic [7:0] dy; } win_t;
  typedef struct packed { logic [11:0] a; logic [7:0] d; } wr_t;

  logic [13:0] rd_q[$];
  win_t        win_q[$];
  wr_t         wr_q[$];
  int          done_q = 0;
  int          total = 0;
  int          bad = 0;
  int          rdly = 0;
  int          resdly = 0;
  bit          res_pending = 1'b0;

  function automatic logic [7:0] rom(input int a);
    return 8'((a * 37 + (a >> 3) + 11) & 255);
  endfunction

  function automatic logic [7:0] eng(input logic [127:0] w, input logic [7:0] dx, input logic [7:0] dy);
    logic [7:0] x;
    x = 8'd0;
    for (int i = 0; i < 16; i++) x = x ^ w[8*i +: 8];
    return 8'(x + 8'(dx * 8'd3) + dy);
  endfunction

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  function automatic void unexpected(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got event=1 want event=0", nm);
  endfunction

  // ROM: data valid the cycle after an enabled read.
  always @(posedge CLK) if (!img_cen) img_data <= rom(int'(img_addr));

  // Interpolation engine with programmable ready and result delays.
  initial begin
    logic [7:0] cap;
    win_ready = 1'b0;
    res_valid = 1'b0;
    res_data  = 8'd0;
    forever begin
      @(posedge CLK); #1;
      if (win_valid && !RST) begin
        repeat (rdly) begin @(posedge CLK); #1; end
        win_ready = 1'b1;
        cap = eng(win_data, win_dx, win_dy);
        @(posedge CLK); #1;
        win_ready   = 1'b0;
        res_pending = 1'b1;
        repeat (resdly) begin @(posedge CLK); #1; end
        res_valid = 1'b1;
        res_data  = cap;
        @(posedge CLK); #1;
        res_valid   = 1'b0;
        res_pending = 1'b0;
      end
    end
  end

  // Monitor: compare every presented output event against the queues.
  always @(negedge CLK) begin
    if (!img_cen) begin
      if (rd_q.size() == 0) unexpected("rom_read");
      else chk("rom_addr", 128'(img_addr), 128'(rd_q.pop_front()));
    end
    if (win_valid) begin
      if (win_q.size() == 0) unexpected("window");
      else begin
        chk("win_data", win_data, win_q[0].d);
        chk("win_dx", 128'(win_dx), 128'(win_q[0].dx));
        chk("win_dy", 128'(win_dy), 128'(win_q[0].dy));
        if (win_ready) void'(win_q.pop_front());
      end
    end
    if (!res_cen || !res_wen) begin
      chk("res_wen", 128'(res_wen), 128'(res_cen));
      chk("write_before_result", 128'(res_pending), 128'(0));
      if (wr_q.size() == 0) unexpected("sram_write");
      else begin
        chk("res_addr", 128'(res_addr), 128'(wr_q[0].a));
        chk("res_d", 128'(res_d), 128'(wr_q[0].d));
        void'(wr_q.pop_front());
      end
    end
    if (DONE) begin
      chk("busy_at_done", 128'(busy), 128'(0));
      chk("queues_drained", 128'(rd_q.size() + win_q.size() + wr_q.size()), 128'(0));
      if (done_q == 0) unexpected("done_pulse");
      else done_q--;
    end
  end

  // Reference model: expected events of a whole job from the scaling rules.
  task automatic model_job(input int v0, input int h0, input int sh, input int sw,
                           input int th, input int tw, output int p);
    int sx, sy, px, py, bx, by, hbx, hby, r, c, a;
    bit have, fetch;
    logic [127:0] w;
    win_t we;
    wr_t  wr;
    sx = (sw * 256) / tw;
    sy = (sh * 256) / th;
    p = 0; have = 0; hbx = 0; hby = 0;
    for (int ty = 0; ty < th; ty++) begin
      for (int tx = 0; tx < tw; tx++) begin
        px = h0 * 256 + tx * sx;
        py = v0 * 256 + ty * sy;
        bx = px / 256;
        by = py / 256;
        fetch = !have || bx != hbx || by != hby;
        for (int k = 0; k < 16; k++) begin
          r = by - 1 + k / 4;
          c = bx - 1 + k % 4;
          if (r < 0) r = 0;
          if (r > 99) r = 99;
          if (c < 0) c = 0;
          if (c > 99) c = 99;
          a = r * 100 + c;
          w[8*k +: 8] = rom(a);
          if (fetch) rd_q.push_back(14'(a));
        end
        p += fetch ? 22 : 5;
        have = 1; hbx = bx; hby = by;
        we.d = w; we.dx = 8'(px % 256); we.dy = 8'(py % 256);
        win_q.push_back(we);
        wr.a = 12'(ty * tw + tx);
        wr.d = eng(w, we.dx, we.dy);
        wr_q.push_back(wr);
      end
    end
    done_q++;
  endtask

  task automatic launch(input int v0, input int h0, input int sh, input int sw,
                        input int th, input int tw);
    V0 = 7'(v0); H0 = 7'(h0); SH = 5'(sh); SW = 5'(sw); TH = 6'(th); TW = 6'(tw);
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    V0 = 7'($urandom); H0 = 7'($urandom); SH = 5'($urandom); SW = 5'($urandom);
    TH = 6'($urandom_range(1, 63)); TW = 6'($urandom_range(1, 63));
  endtask

  task automatic run_job(input int v0, input int h0, input int sh, input int sw,
                         input int th, input int tw, input int rd, input int rs, input bit poke);
    int p, cyc;
    rdly = rd;
    resdly = rs;
    model_job(v0, h0, sh, sw, th, tw, p);
    launch(v0, h0, sh, sw, th, tw);
    cyc = 0;
    while (!DONE && cyc < 20000) begin
      START = (poke && cyc == 40);
      @(posedge CLK); cyc++; #1;
    end
    START = 1'b0;
    if (!DONE) unexpected("done_timeout");
    else if (rd == 0 && rs == 0) chk("job_latency", 128'(cyc), 128'(26 + p));
    @(posedge CLK); #1;
    chk("busy_after_done", 128'(busy), 128'(0));
    chk("done_single_pulse", 128'(DONE), 128'(0));
  endtask

  task automatic check_reset();
    chk("rst_img_cen", 128'(img_cen), 128'(1));
    chk("rst_img_addr", 128'(img_addr), 128'(0));
    chk("rst_win_valid", 128'(win_valid), 128'(0));
    chk("rst_win_data", win_data, 128'(0));
    chk("rst_win_dx", 128'(win_dx), 128'(0));
    chk("rst_win_dy", 128'(win_dy), 128'(0));
    chk("rst_res_cen", 128'(res_cen), 128'(1));
    chk("rst_res_wen", 128'(res_wen), 128'(1));
    chk("rst_res_addr", 128'(res_addr), 128'(0));
    chk("rst_res_d", 128'(res_d), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(DONE), 128'(0));
  endtask

  initial begin
    int p, cyc;
    RST = 1'b1; START = 1'b0;
    V0 = '0; H0 = '0; SH = '0; SW = '0; TH = 6'd1; TW = 6'd1;
    repeat (3) begin @(posedge CLK); #1; end
    check_reset();
    RST = 1'b0;
    @(posedge CLK); #1;

    run_job(10, 10, 4, 4, 4, 4, 0, 0, 1'b0);   // unit scale
    run_job(20, 30, 1, 4, 1, 8, 0, 0, 1'b0);   // upscale with reuse
    run_job(20, 30, 1, 5, 1, 3, 0, 0, 1'b0);   // fractional step 426
    run_job(0, 0, 4, 4, 2, 2, 0, 0, 1'b0);     // top-left clamp
    run_job(50, 98, 1, 1, 1, 1, 0, 0, 1'b0);   // right-edge clamp
    run_job(40, 40, 2, 3, 2, 2, 10, 5, 1'b1);  // backpressure + START while busy

    for (int j = 0; j < 6; j++)
      run_job($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(1, 6), $urandom_range(1, 6),
              $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));

    // Abort a job in FETCH cycle 7.
    rdly = 0; resdly = 0;
    model_job(30, 30, 4, 4, 2, 2, p);
    launch(30, 30, 4, 4, 2, 2);
    cyc = 0;
    while (img_cen && cyc < 200) begin @(posedge CLK); cyc++; #1; end
    if (img_cen) unexpected("fetch_start_timeout");
    repeat (7) begin @(posedge CLK); #1; end
    RST = 1'b1;
    @(posedge CLK); #1;
    rd_q.delete(); win_q.delete(); wr_q.delete(); done_q = 0;
    check_reset();
    @(posedge CLK); #1;
    RST = 1'b0;
    repeat (40) begin @(posedge CLK); #1; end
    run_job(30, 30, 4, 4, 2, 2, 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got running want finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
